// File: rtl/frame_poller.sv
// rtl/frame_poller.sv - Polled frame ring receive engine
// Polls frame headers, streams payload lines through a 2-deep output FIFO, then releases the frame.
module frame_poller #(
  parameter int FRAME_NUMBER_W = 6,
  parameter int FRAME_CHUNKS_W = 6,
  parameter int BASE_W         = 26,
  parameter int POLL_INTERVAL  = 16,
  localparam int ADDR_W        = BASE_W + FRAME_NUMBER_W + FRAME_CHUNKS_W
) (
  input  logic                      clk,
  input  logic                      resetb,
  input  logic                      enable,
  input  logic [BASE_W-1:0]         frame_base_pointer,
  input  logic                      clear_busy,
  output logic                      read_req_valid,
  output logic [ADDR_W-1:0]         read_req_addr,
  input  logic                      read_req_grant,
  input  logic                      read_rsp_valid,
  input  logic [511:0]              read_rsp_data,
  output logic                      out_valid,
  output logic [511:0]              out_data,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      release_frame,
  output logic [FRAME_NUMBER_W-1:0] frame_number,
  output logic [31:0]               frames_received
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POLL_REQ,
    ST_POLL_WAIT,
    ST_BACKOFF,
    ST_DATA_REQ,
    ST_DATA_WAIT,
    ST_RELEASE
  } state_t;

  state_t                    state_q, state_d;
  logic [FRAME_CHUNKS_W-1:0] chunk_q, chunk_d;
  logic [FRAME_CHUNKS_W-1:0] len_q, len_d;
  logic [FRAME_CHUNKS_W-1:0] hdr_len;
  logic [15:0]               bo_cnt_q, bo_cnt_d;
  logic                      req_valid_q, req_valid_d;
  logic [ADDR_W-1:0]         req_addr_q, req_addr_d;
  logic                      release_q, release_d;
  logic [FRAME_NUMBER_W-1:0] frame_q, frame_d;
  logic [31:0]               rx_cnt_q, rx_cnt_d;
  logic                      do_release;
  logic                      granted;
  logic                      push, push_last, pop;
  logic                      head_valid_q, head_valid_d;
  logic                      head_last_q, head_last_d;
  logic [511:0]              head_data_q, head_data_d;
  logic                      sk_valid_q, sk_valid_d;
  logic                      sk_last_q, sk_last_d;
  logic [511:0]              sk_data_q, sk_data_d;
  logic [1:0]                fifo_cnt;

  assign hdr_len  = read_rsp_data[FRAME_CHUNKS_W:1];
  assign granted  = req_valid_q & read_req_grant;
  assign fifo_cnt = {1'b0, head_valid_q} + {1'b0, sk_valid_q};

  always_comb begin
    state_d     = state_q;
    chunk_d     = chunk_q;
    len_d       = len_q;
    bo_cnt_d    = bo_cnt_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    release_d   = 1'b0;
    frame_d     = frame_q;
    rx_cnt_d    = rx_cnt_q;
    do_release  = 1'b0;
    push        = 1'b0;
    push_last   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && !clear_busy) state_d = ST_POLL_REQ;
      end
      ST_POLL_REQ: begin
        if (!req_valid_q) begin
          req_valid_d = 1'b1;
          req_addr_d  = {frame_base_pointer, frame_q, {FRAME_CHUNKS_W{1'b0}}};
        end else if (granted) begin
          req_valid_d = 1'b0;
          state_d     = ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: begin
        if (read_rsp_valid) begin
          if (!read_rsp_data[0]) begin
            bo_cnt_d = '0;
            state_d  = ST_BACKOFF;
          end else if (hdr_len == '0) begin
            do_release = 1'b1;
          end else begin
            len_d   = hdr_len;
            chunk_d = FRAME_CHUNKS_W'(1);
            state_d = ST_DATA_REQ;
          end
        end
      end
      ST_BACKOFF: begin
        if (bo_cnt_q == 16'(POLL_INTERVAL - 1)) state_d = ST_IDLE;
        else bo_cnt_d = bo_cnt_q + 16'd1;
      end
      ST_DATA_REQ: begin
        // Nothing is in flight here, so FIFO room alone decides whether a line may be requested.
        if (!req_valid_q) begin
          if (fifo_cnt < 2'd2) begin
            req_valid_d = 1'b1;
            req_addr_d  = {frame_base_pointer, frame_q, chunk_q};
          end
        end else if (granted) begin
          req_valid_d = 1'b0;
          state_d     = ST_DATA_WAIT;
        end
      end
      ST_DATA_WAIT: begin
        if (read_rsp_valid) begin
          push      = 1'b1;
          push_last = (chunk_q == len_q);
          if (chunk_q == len_q) begin
            do_release = 1'b1;
          end else begin
            chunk_d = chunk_q + FRAME_CHUNKS_W'(1);
            state_d = ST_DATA_REQ;
          end
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (do_release) begin
      release_d = 1'b1;
      frame_d   = frame_q + FRAME_NUMBER_W'(1);
      rx_cnt_d  = rx_cnt_q + 32'd1;
      state_d   = ST_RELEASE;
    end
  end

  always_comb begin
    head_valid_d = head_valid_q;
    head_last_d  = head_last_q;
    head_data_d  = head_data_q;
    sk_valid_d   = sk_valid_q;
    sk_last_d    = sk_last_q;
    sk_data_d    = sk_data_q;
    pop          = head_valid_q & out_ready;
    if (push) begin
      if (!head_valid_q || (pop && !sk_valid_q)) begin
        head_valid_d = 1'b1;
        head_last_d  = push_last;
        head_data_d  = read_rsp_data;
      end else if (pop) begin
        head_last_d = sk_last_q;
        head_data_d = sk_data_q;
        sk_last_d   = push_last;
        sk_data_d   = read_rsp_data;
      end else begin
        sk_valid_d = 1'b1;
        sk_last_d  = push_last;
        sk_data_d  = read_rsp_data;
      end
    end else if (pop) begin
      if (sk_valid_q) begin
        head_last_d = sk_last_q;
        head_data_d = sk_data_q;
        sk_valid_d  = 1'b0;
      end else begin
        head_valid_d = 1'b0;
        head_last_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      chunk_q      <= '0;
      len_q        <= '0;
      bo_cnt_q     <= '0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      release_q    <= 1'b0;
      frame_q      <= '0;
      rx_cnt_q     <= '0;
      head_valid_q <= 1'b0;
      head_last_q  <= 1'b0;
      head_data_q  <= '0;
      sk_valid_q   <= 1'b0;
      sk_last_q    <= 1'b0;
      sk_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      chunk_q      <= chunk_d;
      len_q        <= len_d;
      bo_cnt_q     <= bo_cnt_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      release_q    <= release_d;
      frame_q      <= frame_d;
      rx_cnt_q     <= rx_cnt_d;
      head_valid_q <= head_valid_d;
      head_last_q  <= head_last_d;
      head_data_q  <= head_data_d;
      sk_valid_q   <= sk_valid_d;
      sk_last_q    <= sk_last_d;
      sk_data_q    <= sk_data_d;
    end
  end

  assign read_req_valid  = req_valid_q;
  assign read_req_addr   = req_addr_q;
  assign out_valid       = head_valid_q;
  assign out_data        = head_data_q;
  assign out_last        = head_last_q;
  assign release_frame   = release_q;
  assign frame_number    = frame_q;
  assign frames_received = rx_cnt_q;

endmodule

// File: tb/tb_frame_poller.sv
// tb/tb_frame_poller.sv - Scoreboard bench for frame_poller
// Host memory/arbiter model answers reads; expected addresses and beats are queued per scenario.
module tb_frame_poller;
  localparam int FNW = 6;
  localparam int FCW = 6;
  localparam int BW  = 26;
  localparam int PI  = 16;
  localparam int AW  = BW + FNW + FCW;
  localparam logic [BW-1:0] BASE = 26'h2B3C4D5;

  logic           clk, resetb, enable, clear_busy;
  logic [BW-1:0]  frame_base_pointer;
  logic           read_req_valid, read_req_grant, read_rsp_valid;
  logic [AW-1:0]  read_req_addr;
  logic [511:0]   read_rsp_data, out_data;
  logic           out_valid, out_last, out_ready, release_frame;
  logic [FNW-1:0] frame_number;
  logic [31:0]    frames_received;

  int compared, mismatched, cyc, grants, rel_cnt, rsp_lat, bad_polls, pend_cnt;
  bit pend, grant_en;
  logic [AW-1:0] pend_addr;
  bit hdr_ok [64];
  int hdr_len [64];
  logic [512:0]  exp_beats[$];
  logic [AW-1:0] exp_addr[$];
  int poll_cyc[$];

  frame_poller #(.FRAME_NUMBER_W(FNW), .FRAME_CHUNKS_W(FCW), .BASE_W(BW), .POLL_INTERVAL(PI)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .frame_base_pointer(frame_base_pointer),
    .clear_busy(clear_busy), .read_req_valid(read_req_valid), .read_req_addr(read_req_addr),
    .read_req_grant(read_req_grant), .read_rsp_valid(read_rsp_valid), .read_rsp_data(read_rsp_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .release_frame(release_frame), .frame_number(frame_number), .frames_received(frames_received)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [511:0] data_for(input int f, input int c);
    logic [31:0] w;
    w = {f[7:0], c[7:0], 16'hBEEF ^ {f[7:0], c[7:0]}};
    return {16{w}};
  endfunction

  function automatic logic [AW-1:0] addr_of(input int f, input int c);
    return {BASE, f[5:0], c[5:0]};
  endfunction

  // One clock of host model plus scoreboard comparison of whatever the DUT produced.
  task automatic step();
    logic         take, l;
    logic [511:0] d, line;
    logic [512:0] e;
    logic [AW-1:0] ea;
    int f, c;
    take = out_valid && out_ready && resetb;
    d = out_data;
    l = out_last;
    @(negedge clk);
    cyc++;
    if (take) begin
      compared++;
      if (exp_beats.size() == 0) begin
        mismatched++;
        $display("FAIL beat_unexpected: got last=%0b data[63:0]=%h, required no beat", l, d[63:0]);
      end else begin
        e = exp_beats.pop_front();
        if ({l, d} !== e) begin
          mismatched++;
          $display("FAIL beat: got last=%0b data[63:0]=%h, required last=%0b data[63:0]=%h",
                   l, d[63:0], e[512], e[63:0]);
        end
      end
    end
    if (release_frame) rel_cnt++;
    read_rsp_valid = 1'b0;
    if (pend) begin
      if (pend_cnt == 0) begin
        f = int'(pend_addr[11:6]);
        c = int'(pend_addr[5:0]);
        line = data_for(f, c);
        if (c == 0) begin
          if (bad_polls > 0) begin
            line[0] = 1'b0;
            bad_polls--;
          end else begin
            line[0] = hdr_ok[f];
          end
          line[6:1] = 6'(hdr_len[f]);
        end
        read_rsp_data  = line;
        read_rsp_valid = 1'b1;
        pend = 1'b0;
      end else begin
        pend_cnt--;
      end
    end
    read_req_grant = grant_en && read_req_valid;
    if (read_req_grant) begin
      grants++;
      compared++;
      if (exp_addr.size() == 0) begin
        mismatched++;
        $display("FAIL req_unexpected: got addr=%h, required no request", read_req_addr);
      end else begin
        ea = exp_addr.pop_front();
        if (read_req_addr !== ea) begin
          mismatched++;
          $display("FAIL req_addr: got %h, required %h", read_req_addr, ea);
        end
      end
      if (read_req_addr[5:0] == 6'd0) poll_cyc.push_back(cyc);
      pend      = 1'b1;
      pend_cnt  = rsp_lat;
      pend_addr = read_req_addr;
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    for (int i = 0; i < 3; i++) step();
    compared += 7;
    if (read_req_valid !== 1'b0) begin mismatched++; $display("FAIL rst_req_valid: got %b, required 0", read_req_valid); end
    if (read_req_addr !== '0) begin mismatched++; $display("FAIL rst_req_addr: got %h, required 0", read_req_addr); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    if (out_last !== 1'b0) begin mismatched++; $display("FAIL rst_out_last: got %b, required 0", out_last); end
    if (release_frame !== 1'b0) begin mismatched++; $display("FAIL rst_release: got %b, required 0", release_frame); end
    if (frame_number !== 6'd0) begin mismatched++; $display("FAIL rst_frame_number: got %0d, required 0", frame_number); end
    if (frames_received !== 32'd0) begin mismatched++; $display("FAIL rst_frames_received: got %0d, required 0", frames_received); end
    resetb = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int n;
    hdr_ok[0] = 1'b1;
    hdr_len[0] = 3;
    for (int c = 0; c <= 3; c++) exp_addr.push_back(addr_of(0, c));
    for (int c = 1; c <= 3; c++) exp_beats.push_back({c == 3, data_for(0, c)});
    rel_cnt = 0; out_ready = 1'b1; enable = 1'b1; n = 0;
    while ((rel_cnt < 1 || exp_beats.size() > 0) && n < 300) begin
      step(); n++;
      if (rel_cnt >= 1) enable = 1'b0;
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    compared += 5;
    if (rel_cnt != 1) begin mismatched++; $display("FAIL basic_release_pulses: got %0d, required 1", rel_cnt); end
    if (frame_number !== 6'd1) begin mismatched++; $display("FAIL basic_frame_number: got %0d, required 1", frame_number); end
    if (frames_received !== 32'd1) begin mismatched++; $display("FAIL basic_frames_received: got %0d, required 1", frames_received); end
    if (exp_addr.size() != 0) begin mismatched++; $display("FAIL basic_reqs_missing: got %0d left, required 0", exp_addr.size()); end
    if (exp_beats.size() != 0) begin mismatched++; $display("FAIL basic_beats_missing: got %0d left, required 0", exp_beats.size()); end
  endtask

  task automatic test_backoff();
    int n, gap0, gap1;
    hdr_ok[1] = 1'b1;
    hdr_len[1] = 1;
    bad_polls = 2;
    poll_cyc.delete();
    for (int i = 0; i < 3; i++) exp_addr.push_back(addr_of(1, 0));
    exp_addr.push_back(addr_of(1, 1));
    exp_beats.push_back({1'b1, data_for(1, 1)});
    rel_cnt = 0; enable = 1'b1; n = 0;
    while ((rel_cnt < 1 || exp_beats.size() > 0) && n < 400) begin
      step(); n++;
      if (rel_cnt >= 1) enable = 1'b0;
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    gap0 = (poll_cyc.size() >= 3) ? poll_cyc[1] - poll_cyc[0] : 0;
    gap1 = (poll_cyc.size() >= 3) ? poll_cyc[2] - poll_cyc[1] : 0;
    compared += 6;
    if (poll_cyc.size() != 3) begin mismatched++; $display("FAIL backoff_polls: got %0d, required 3", poll_cyc.size()); end
    if (gap0 < PI + 2) begin mismatched++; $display("FAIL backoff_gap0: got %0d cycles, required >= %0d", gap0, PI + 2); end
    if (gap1 < PI + 2) begin mismatched++; $display("FAIL backoff_gap1: got %0d cycles, required >= %0d", gap1, PI + 2); end
    if (rel_cnt != 1) begin mismatched++; $display("FAIL backoff_release_pulses: got %0d, required 1", rel_cnt); end
    if (frame_number !== 6'd2) begin mismatched++; $display("FAIL backoff_frame_number: got %0d, required 2", frame_number); end
    if (exp_beats.size() != 0 || exp_addr.size() != 0) begin
      mismatched++; $display("FAIL backoff_leftover: got %0d beats %0d reqs, required 0 0", exp_beats.size(), exp_addr.size());
    end
  endtask

  task automatic test_backpressure();
    int n, g0;
    hdr_ok[2] = 1'b1;
    hdr_len[2] = 5;
    for (int c = 0; c <= 5; c++) exp_addr.push_back(addr_of(2, c));
    for (int c = 1; c <= 5; c++) exp_beats.push_back({c == 5, data_for(2, c)});
    g0 = grants; rel_cnt = 0; out_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 40; i++) step();
    compared += 3;
    if (grants - g0 != 3) begin mismatched++; $display("FAIL bp_reads_stalled: got %0d reads, required 3", grants - g0); end
    if (read_req_valid !== 1'b0) begin mismatched++; $display("FAIL bp_req_held: got %b, required 0", read_req_valid); end
    if (out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
    n = 0;
    while ((rel_cnt < 1 || exp_beats.size() > 0) && n < 400) begin
      out_ready = (n % 3) != 2;
      step(); n++;
      if (rel_cnt >= 1) enable = 1'b0;
    end
    enable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    compared += 3;
    if (exp_beats.size() != 0) begin mismatched++; $display("FAIL bp_beats_missing: got %0d left, required 0", exp_beats.size()); end
    if (rel_cnt != 1) begin mismatched++; $display("FAIL bp_release_pulses: got %0d, required 1", rel_cnt); end
    if (frames_received !== 32'd3) begin mismatched++; $display("FAIL bp_frames_received: got %0d, required 3", frames_received); end
  endtask

  task automatic test_wrap();
    int n;
    bit saw_zero;
    for (int f = 0; f < 64; f++) begin hdr_ok[f] = 1'b1; hdr_len[f] = 0; end
    for (int i = 0; i < 64; i++) exp_addr.push_back(addr_of((3 + i) % 64, 0));
    rel_cnt = 0; enable = 1'b1; n = 0; saw_zero = 1'b0;
    while (rel_cnt < 64 && n < 2000) begin
      step(); n++;
      if (frame_number == 6'd0) saw_zero = 1'b1;
      if (rel_cnt >= 64) enable = 1'b0;
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    compared += 6;
    if (rel_cnt != 64) begin mismatched++; $display("FAIL wrap_release_pulses: got %0d, required 64", rel_cnt); end
    if (frame_number !== 6'd3) begin mismatched++; $display("FAIL wrap_frame_number: got %0d, required 3", frame_number); end
    if (frames_received !== 32'd67) begin mismatched++; $display("FAIL wrap_frames_received: got %0d, required 67", frames_received); end
    if (!saw_zero) begin mismatched++; $display("FAIL wrap_to_zero: got no frame 0, required wrap 63->0"); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL wrap_out_valid: got %b, required 0", out_valid); end
    if (exp_addr.size() != 0) begin mismatched++; $display("FAIL wrap_reqs_missing: got %0d left, required 0", exp_addr.size()); end
  endtask

  task automatic test_clear_busy();
    int n, g1;
    hdr_len[3] = 2;
    hdr_len[4] = 2;
    for (int c = 0; c <= 2; c++) exp_addr.push_back(addr_of(3, c));
    for (int c = 1; c <= 2; c++) exp_beats.push_back({c == 2, data_for(3, c)});
    rel_cnt = 0; clear_busy = 1'b0; enable = 1'b1; n = 0;
    while ((rel_cnt < 1 || exp_beats.size() > 0) && n < 300) begin
      step(); n++;
      if (rel_cnt >= 1) clear_busy = 1'b1;
    end
    g1 = grants;
    for (int i = 0; i < 30; i++) step();
    compared += 3;
    if (grants != g1) begin mismatched++; $display("FAIL cb_blocked_reads: got %0d, required 0", grants - g1); end
    if (read_req_valid !== 1'b0) begin mismatched++; $display("FAIL cb_req_valid: got %b, required 0", read_req_valid); end
    if (frame_number !== 6'd4) begin mismatched++; $display("FAIL cb_frame_number: got %0d, required 4", frame_number); end
    for (int c = 0; c <= 2; c++) exp_addr.push_back(addr_of(4, c));
    for (int c = 1; c <= 2; c++) exp_beats.push_back({c == 2, data_for(4, c)});
    rel_cnt = 0; clear_busy = 1'b0; n = 0;
    while (grants < g1 + 2 && n < 300) begin step(); n++; end
    enable = 1'b0;
    n = 0;
    while ((rel_cnt < 1 || exp_beats.size() > 0) && n < 300) begin step(); n++; end
    for (int i = 0; i < 30; i++) step();
    compared += 5;
    if (grants != g1 + 3) begin mismatched++; $display("FAIL cb_frame_reads: got %0d, required 3", grants - g1); end
    if (rel_cnt != 1) begin mismatched++; $display("FAIL cb_release_pulses: got %0d, required 1", rel_cnt); end
    if (frame_number !== 6'd5) begin mismatched++; $display("FAIL cb_idle_frame_number: got %0d, required 5", frame_number); end
    if (frames_received !== 32'd69) begin mismatched++; $display("FAIL cb_frames_received: got %0d, required 69", frames_received); end
    if (exp_beats.size() != 0 || exp_addr.size() != 0) begin
      mismatched++; $display("FAIL cb_leftover: got %0d beats %0d reqs, required 0 0", exp_beats.size(), exp_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, g0;
    hdr_len[5] = 3;
    exp_addr.push_back(addr_of(5, 0));
    exp_addr.push_back(addr_of(5, 1));
    for (int c = 1; c <= 3; c++) exp_beats.push_back({c == 3, data_for(5, c)});
    g0 = grants; rsp_lat = 6; enable = 1'b1; n = 0;
    while (grants < g0 + 2 && n < 300) begin step(); n++; end
    step();
    resetb = 1'b0;
    #1;
    compared += 7;
    if (read_req_valid !== 1'b0) begin mismatched++; $display("FAIL mid_req_valid: got %b, required 0", read_req_valid); end
    if (read_req_addr !== '0) begin mismatched++; $display("FAIL mid_req_addr: got %h, required 0", read_req_addr); end
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_out_valid: got %b, required 0", out_valid); end
    if (out_last !== 1'b0) begin mismatched++; $display("FAIL mid_out_last: got %b, required 0", out_last); end
    if (release_frame !== 1'b0) begin mismatched++; $display("FAIL mid_release: got %b, required 0", release_frame); end
    if (frame_number !== 6'd0) begin mismatched++; $display("FAIL mid_frame_number: got %0d, required 0", frame_number); end
    if (frames_received !== 32'd0) begin mismatched++; $display("FAIL mid_frames_received: got %0d, required 0", frames_received); end
    exp_beats.delete();
    enable = 1'b0;
    step(); step();
    resetb = 1'b1;
    for (int i = 0; i < 12; i++) step();
    compared += 2;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_late_rsp_beat: got %b, required 0", out_valid); end
    if (read_req_valid !== 1'b0) begin mismatched++; $display("FAIL mid_idle_req: got %b, required 0", read_req_valid); end
    rsp_lat = 0;
    exp_addr.push_back(addr_of(0, 0));
    g0 = grants; rel_cnt = 0; enable = 1'b1; n = 0;
    while (grants < g0 + 1 && n < 100) begin step(); n++; end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) step();
    compared += 4;
    if (exp_addr.size() != 0) begin mismatched++; $display("FAIL mid_first_poll: got %0d reqs missing, required 0", exp_addr.size()); end
    if (rel_cnt != 1) begin mismatched++; $display("FAIL mid_release_pulses: got %0d, required 1", rel_cnt); end
    if (frames_received !== 32'd1) begin mismatched++; $display("FAIL mid_frames_after: got %0d, required 1", frames_received); end
    if (frame_number !== 6'd1) begin mismatched++; $display("FAIL mid_frame_after: got %0d, required 1", frame_number); end
  endtask

  initial begin
    compared = 0; mismatched = 0; cyc = 0; grants = 0; rel_cnt = 0;
    rsp_lat = 0; bad_polls = 0; pend = 1'b0; pend_cnt = 0; pend_addr = '0; grant_en = 1'b1;
    for (int f = 0; f < 64; f++) begin hdr_ok[f] = 1'b0; hdr_len[f] = 0; end
    resetb = 1'b0; enable = 1'b0; clear_busy = 1'b0; out_ready = 1'b1;
    frame_base_pointer = BASE;
    read_req_grant = 1'b0; read_rsp_valid = 1'b0; read_rsp_data = '0;
    test_reset();
    test_basic();
    test_backoff();
    test_backpressure();
    test_wrap();
    test_clear_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frame_poller.md
# frame_poller

Host-to-FPGA receive side of the polled frame ring. Polls the header line of the current frame in host memory, and on finding it valid reads its payload lines in order and streams them to the consumer. After the last line it pulses `release_frame`, which feeds `frame_release` so the header gets cleared, and then advances to the next frame with wrap-around. The block sits between the read-channel arbiter and the channel consumer logic.

## Interface
- `FRAME_NUMBER_W`, 6: log2 of frames in the ring (64 frames).
- `FRAME_CHUNKS_W`, 6: log2 of lines per frame. Chunk 0 is the header; payload is at most 2^W−1 lines.
- `BASE_W`, 26: width of the frame base pointer. Line address width `ADDR_W` = `BASE_W`+`FRAME_NUMBER_W`+`FRAME_CHUNKS_W`.
- `POLL_INTERVAL`, 16: idle cycles between a not-valid header response and the next re-poll (≥1, 16-bit).

Ports:
- `clk` in 1: clock.
- `resetb` in 1: reset, asynchronous, active-low.
- `enable` in 1: polling enable (CSR).
- `frame_base_pointer` in BASE_W: ring base line address. Stable while `enable`=1.
- `clear_busy` in 1: `frame_release` still has frames to clear.
- `read_req_valid` out 1: read request.
- `read_req_addr` out ADDR_W: line address `{frame_base_pointer, frame_number, chunk}`.
- `read_req_grant` in 1: arbiter accepts request this cycle.
- `read_rsp_valid` in 1: one-cycle read response.
- `read_rsp_data` in 512: response line.
- `out_valid` out 1, `out_data` out 512, `out_last` out 1: payload stream.
- `out_ready` in 1: consumer accepts the beat.
- `release_frame` out 1: one-cycle pulse per consumed frame.
- `frame_number` out FRAME_NUMBER_W: frame currently polled or read.
- `frames_received` out 32: count of frames released. Wraps.

## Operation
- Header format: `data[0]` = valid; `data[FRAME_CHUNKS_W:1]` = payload line count L.
- At most one read is outstanding at any time. Responses return in order by construction.
- Handshake: `read_req_valid` and `read_req_addr` are held until the cycle with `read_req_grant`=1. The request is considered issued in that cycle.
- FSM states:
  - IDLE: if `enable`=1 and `clear_busy`=0, go to POLL_REQ.
  - POLL_REQ: request chunk 0 of `frame_number`. On grant, go to POLL_WAIT.
  - POLL_WAIT: wait for the response.
    - valid=0: go to BACKOFF.
    - valid=1 and L=0: go to RELEASE.
    - valid=1 and L>0: latch L, set chunk=1, go to DATA_REQ.
  - BACKOFF: count `POLL_INTERVAL` cycles, then go to IDLE.
  - DATA_REQ: issue a request only when (FIFO occupancy + in-flight) < 2. On grant, go to DATA_WAIT.
  - DATA_WAIT: on response, push the line into the FIFO with `out_last` = (chunk==L).
    - If chunk==L, go to RELEASE.
    - Otherwise chunk++ and go to DATA_REQ.
  - RELEASE: assert `release_frame` for 1 cycle, `frame_number`++ (wraps modulo 2^FRAME_NUMBER_W), `frames_received`++, then go to IDLE.
- Output: a 2-entry FIFO drives `out_*`. A beat transfers when `out_valid` and `out_ready` are both 1. Release does not wait for the FIFO to drain.
- `enable`=0 is honoured only in IDLE. A frame in progress (including its outstanding read) completes normally.
- `clear_busy`=1 blocks the IDLE→POLL_REQ transition only. This prevents reading a stale header of a not-yet-cleared frame after ring wrap.
- A response arriving with no read outstanding is ignored.

## Timing
- Reset values: `read_req_valid`=0, `read_req_addr`=0, `out_valid`=0, `out_last`=0, `release_frame`=0, `frame_number`=0, `frames_received`=0, FSM=IDLE, FIFO empty.
- All outputs are registered.
- Request latency: `read_req_valid` rises the cycle after entering POLL_REQ or DATA_REQ.
- Response to FIFO: a response in cycle t gives `out_valid`=1 at t+1 if the FIFO was empty.
- `release_frame` rises the cycle after the last data response, or after the header response when L=0.
- Reset mid-operation: all state returns to reset values immediately. The outstanding read is abandoned.
- Minimum re-poll period: grant + response latency + `POLL_INTERVAL` + 2 cycles.

## Test plan
- Reset then `enable`=1, header valid with L=3, zero-latency grants, `out_ready`=1:
  - Reads are issued to chunks 0,1,2,3 of frame 0.
  - Three beats appear, with `out_last` only on the third.
  - One `release_frame` pulse; `frame_number`=1, `frames_received`=1.
- Header valid=0 twice, then valid with L=1, `POLL_INTERVAL`=16:
  - Three header reads, spaced ≥16 idle cycles apart.
  - Exactly one beat, then release.
- `out_ready`=0 with L=5:
  - Exactly 2 data reads are issued, and no further request is made until `out_ready`=1.
  - Data arrives in order with no loss.
- 64 consecutive frames with L=0:
  - 64 release pulses; `frame_number` wraps 63→0; no `out_valid`.
- `clear_busy`=1 held in IDLE after a release:
  - No read request until `clear_busy` falls.
  - `enable` dropped mid-frame: the frame completes and the block then stays in IDLE.
- Assert `resetb`=0 while a data read is outstanding, then release reset:
  - All outputs go to reset values immediately.
  - A late response is ignored, and the next request is the chunk-0 poll of frame 0.
